// File: rtl/fast_bconv_sk.sv
// fast_bconv_sk: Shenoy-Kumaresan exact base converter, basis B (+ m_sk) -> basis q.
// The m_sk residue recovers the B-overflow count gamma, which is removed from
// the fast-converted sum so that the q-residues are exact.
// Optional feature macro: FAST_BCONV_SK_CENTER_EN (centered gamma correction).
package fast_bconv_sk_pkg;
    localparam int RES_W = 64;
    typedef logic [RES_W-1:0]   rns_residue_t;
    typedef logic [2*RES_W-1:0] wide_rns_residue_t;
endpackage

module fast_bconv_sk
    import fast_bconv_sk_pkg::*;
#(
    parameter int           B_BASIS_LEN = 2,
    parameter int           Q_BASIS_LEN = 2,
    parameter rns_residue_t B_BASIS [B_BASIS_LEN] = '{64'd7, 64'd11},
    parameter rns_residue_t Q_BASIS [Q_BASIS_LEN] = '{64'd5, 64'd17},
    parameter rns_residue_t MSK = 64'd13,
    parameter rns_residue_t ZiLUT [B_BASIS_LEN] = '{64'd2, 64'd8},
    parameter rns_residue_t YMODQ [Q_BASIS_LEN][B_BASIS_LEN] =
        '{'{64'd1, 64'd2}, '{64'd11, 64'd7}},
    parameter rns_residue_t YMODMSK [B_BASIS_LEN] = '{64'd11, 64'd7},
    parameter rns_residue_t B_INV_MSK = 64'd12,
    parameter rns_residue_t B_MODQ [Q_BASIS_LEN] = '{64'd2, 64'd9}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  rns_residue_t input_RNSint [B_BASIS_LEN],
    input  rns_residue_t input_msk,
    output logic         busy,
    output logic         out_valid,
    output rns_residue_t output_RNSint [Q_BASIS_LEN]
);

    localparam int IDX_W = (B_BASIS_LEN > 1) ? $clog2(B_BASIS_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(B_BASIS_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCALE, S_ACCUM, S_GAMMA, S_CORRECT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    rns_residue_t     x_q    [B_BASIS_LEN];
    rns_residue_t     a_q    [B_BASIS_LEN];
    rns_residue_t     s_q    [Q_BASIS_LEN];
    rns_residue_t     out_q  [Q_BASIS_LEN];
    rns_residue_t     xmsk_q, smsk_q, gamma_q;

    // Full-width product, reduced straight away so stored values stay < m.
    function automatic rns_residue_t mulmod(input rns_residue_t a, input rns_residue_t b,
                                            input rns_residue_t m);
        wide_rns_residue_t p;
        p = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
        return rns_residue_t'(p % wide_rns_residue_t'(m));
    endfunction

    // Both operands already reduced, so a single conditional subtract suffices.
    function automatic rns_residue_t addmod(input rns_residue_t a, input rns_residue_t b,
                                            input rns_residue_t m);
        wide_rns_residue_t s;
        s = wide_rns_residue_t'(a) + wide_rns_residue_t'(b);
        if (s >= wide_rns_residue_t'(m)) s = s - wide_rns_residue_t'(m);
        return rns_residue_t'(s);
    endfunction

    // a - b computed as a + (m - b) to stay non-negative.
    function automatic rns_residue_t submod(input rns_residue_t a, input rns_residue_t b,
                                            input rns_residue_t m);
        return addmod(a, m - b, m);
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign output_RNSint = out_q;

    // Next-state logic: fixed sequence, only IDLE waits on the request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_valid) state_d = S_SCALE;
            S_SCALE:   state_d = S_ACCUM;
            S_ACCUM:   if (idx_q == IDX_LAST) state_d = S_GAMMA;
            S_GAMMA:   state_d = S_CORRECT;
            S_CORRECT: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: capture, scale, serial accumulate, gamma, correction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            xmsk_q  <= '0;
            smsk_q  <= '0;
            gamma_q <= '0;
            for (int i = 0; i < B_BASIS_LEN; i++) begin
                x_q[i] <= '0;
                a_q[i] <= '0;
            end
            for (int j = 0; j < Q_BASIS_LEN; j++) begin
                s_q[j]   <= '0;
                out_q[j] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < B_BASIS_LEN; i++) x_q[i] <= input_RNSint[i];
                        xmsk_q <= input_msk;
                    end
                end
                S_SCALE: begin
                    for (int i = 0; i < B_BASIS_LEN; i++)
                        a_q[i] <= mulmod(x_q[i], ZiLUT[i], B_BASIS[i]);
                    for (int j = 0; j < Q_BASIS_LEN; j++) s_q[j] <= '0;
                    smsk_q <= '0;
                    idx_q  <= '0;
                end
                S_ACCUM: begin
                    for (int j = 0; j < Q_BASIS_LEN; j++)
                        s_q[j] <= addmod(s_q[j], mulmod(a_q[idx_q], YMODQ[j][idx_q], Q_BASIS[j]),
                                         Q_BASIS[j]);
                    smsk_q <= addmod(smsk_q, mulmod(a_q[idx_q], YMODMSK[idx_q], MSK), MSK);
                    idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
                S_GAMMA: begin
                    gamma_q <= mulmod(submod(smsk_q, xmsk_q, MSK), B_INV_MSK, MSK);
                end
                S_CORRECT: begin
                    for (int j = 0; j < Q_BASIS_LEN; j++) begin
`ifdef FAST_BCONV_SK_CENTER_EN
                        // Large gamma is read as the negative overflow gamma - MSK.
                        if (gamma_q <= (MSK >> 1))
                            out_q[j] <= submod(s_q[j], mulmod(gamma_q, B_MODQ[j], Q_BASIS[j]),
                                               Q_BASIS[j]);
                        else
                            out_q[j] <= addmod(s_q[j], mulmod(MSK - gamma_q, B_MODQ[j], Q_BASIS[j]),
                                               Q_BASIS[j]);
`else
                        out_q[j] <= submod(s_q[j], mulmod(gamma_q, B_MODQ[j], Q_BASIS[j]),
                                           Q_BASIS[j]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fast_bconv_sk.sv
// Bench for fast_bconv_sk on the small basis B={7,11}, m_sk=13, q={5,17}.
// The reference model works with exact integers derived from the bases.
module tb_fast_bconv_sk;
    import fast_bconv_sk_pkg::*;

    localparam int L = 2;
    localparam int Q = 2;
    localparam longint BB [L] = '{7, 11};
    localparam longint QQ [Q] = '{5, 17};
    localparam longint M = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    rns_residue_t xin [L];
    rns_residue_t xm;
    logic         busy, out_valid;
    rns_residue_t yout [Q];

    fast_bconv_sk #(
        .B_BASIS_LEN(L), .Q_BASIS_LEN(Q),
        .B_BASIS('{64'd7, 64'd11}), .Q_BASIS('{64'd5, 64'd17}), .MSK(64'd13),
        .ZiLUT('{64'd2, 64'd8}), .YMODQ('{'{64'd1, 64'd2}, '{64'd11, 64'd7}}),
        .YMODMSK('{64'd11, 64'd7}), .B_INV_MSK(64'd12), .B_MODQ('{64'd2, 64'd9})
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .input_RNSint(xin), .input_msk(xm),
        .busy(busy), .out_valid(out_valid), .output_RNSint(yout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    int busy_cnt = 0;
    longint exp0 [$];
    longint exp1 [$];
    int     acc_q [$];
    int     acc_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Exact-integer reference: fast conversion sum, overflow from m_sk, correction.
    function automatic longint model_out(input int j, input longint r0, input longint r1,
                                         input longint rm);
        longint r [L];
        longint bp, s, g, binv, zi, v, q, bi;
        r[0] = r0; r[1] = r1;
        bp = 1;
        for (int i = 0; i < L; i++) bp = bp * BB[i];
        s = 0;
        for (int i = 0; i < L; i++) begin
            bi = BB[i];
            zi = 0;
            for (longint z = 1; z < bi; z++)
                if ((((bp / bi) % bi) * z) % bi == 1) zi = z;
            s = s + ((r[i] * zi) % bi) * (bp / bi);
        end
        binv = 0;
        for (longint z = 1; z < M; z++)
            if (((bp % M) * z) % M == 1) binv = z;
        g = ((((s - rm) % M) + M) % M * binv) % M;
`ifdef FAST_BCONV_SK_CENTER_EN
        if (g > M / 2) v = s + (M - g) * bp;
        else           v = s - g * bp;
`else
        v = s - g * bp;
`endif
        q = QQ[j];
        return ((v % q) + q) % q;
    endfunction

    // Accept capture: sampled before the edge's state update takes effect.
    always @(posedge clk) begin
        if (reset && in_valid && !busy) begin
            exp0.push_back(model_out(0, longint'(xin[0]), longint'(xin[1]), longint'(xm)));
            exp1.push_back(model_out(1, longint'(xin[0]), longint'(xin[1]), longint'(xm)));
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
    end

    // Compare process: every out_valid cycle must match the oldest accepted request.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                pulses++;
                chk("out_valid_has_request", 64'(exp0.size() != 0), 64'd1);
                if (exp0.size() != 0) begin
                    chk("model_out0", yout[0], 64'(exp0.pop_front()));
                    chk("model_out1", yout[1], 64'(exp1.pop_front()));
                    chk("latency_cycles", 64'(cyc - acc_q.pop_front() - 1), 64'(L + 3));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm);
        for (int k = 0; k < 40 && !out_valid; k++) tick();
        chk({nm, "_seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic conv(input string nm, input longint r0, input longint r1, input longint rm,
                        input longint e0, input longint e1);
        xin[0] = 64'(r0); xin[1] = 64'(r1); xm = 64'(rm);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(nm);
        chk({nm, "_q0"}, yout[0], 64'(e0));
        chk({nm, "_q1"}, yout[1], 64'(e1));
        tick();
        chk({nm, "_pulse_one_cycle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int p0, x;
        xin[0] = '0; xin[1] = '0; xm = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q0", yout[0], 64'd0);
        chk("rst_q1", yout[1], 64'd0);
        tick();
        reset = 1'b1;
        tick(); tick();

        conv("x20", 6, 9, 7, 0, 3);

        busy_cnt = 0;
        conv("x0", 0, 0, 0, 0, 0);
        tick();
        chk("x0_busy_cycles", 64'(busy_cnt), 64'd6);

`ifdef FAST_BCONV_SK_CENTER_EN
        conv("center", 6, 9, 5, 4, 4);
`else
        conv("center", 6, 9, 5, 3, 6);
`endif

        // Held in_valid across two conversions.
        p0 = pulses;
        acc_log.delete();
        xin[0] = 64'd6; xin[1] = 64'd9; xm = 64'd7;
        in_valid = 1'b1;
        wait_out("held1");
        chk("held1_q0", yout[0], 64'd0);
        chk("held1_q1", yout[1], 64'd3);
        xin[0] = 64'd6; xin[1] = 64'd10; xm = 64'd11;
        tick();
        for (int k = 0; k < 10 && !busy; k++) tick();
        in_valid = 1'b0;
        wait_out("held2");
        chk("held2_q0", yout[0], 64'd1);
        chk("held2_q1", yout[1], 64'd8);
        tick(); tick(); tick();
        chk("held_pulses", 64'(pulses - p0), 64'd2);
        chk("held_accepts", 64'(acc_log.size()), 64'd2);
        if (acc_log.size() == 2)
            chk("held_accept_interval", 64'(acc_log[1] - acc_log[0]), 64'(L + 5));

        // Asynchronous reset in the middle of ACCUM.
        p0 = pulses;
        xin[0] = 64'd6; xin[1] = 64'd9; xm = 64'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_q0", yout[0], 64'd0);
        chk("arst_q1", yout[1], 64'd0);
        exp0.delete(); exp1.delete(); acc_q.delete();
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("arst_no_pulse", 64'(pulses - p0), 64'd0);
        conv("post_rst_x20", 6, 9, 7, 0, 3);

        // Random consistent x below B: exact result is x mod q_j in both builds.
        for (int n = 0; n < 100; n++) begin
            x = int'($urandom_range(0, 76));
            conv("rand", longint'(x % 7), longint'(x % 11), longint'(x % 13),
                 longint'(x % 5), longint'(x % 17));
        end

        tick(); tick();
        chk("queue_drained", 64'(exp0.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
